uart_fifo_periph: RTL and testbench
===================================

// Module: uart_fifo_periph
// PURPOSE
//  Memory-mapped UART with parametrised TX/RX FIFOs, a programmable baud divisor and a maskable interrupt.
//  Next generation of the system's UART path: replaces the single-byte, separately clocked UART on the peripheral bus.
//  Runs entirely on the CPU clock and decodes its own register window.
// PARAMETERS
//  BASE_ADDR    32'h4000_0020  base of the 16-byte register window (addr[31:4] compare)
//  FIFO_DEPTH   16             entries per FIFO; power of two, >=2
//  BAUD_DIV_RST 16'd324        reset divisor: 16x tick every DIV+1 clk (50 MHz -> 9600 baud)
// PORTS
//  clk      in   1   system clock, all logic rising-edge
//  reset    in   1   asynchronous, active-low reset
//  rd       in   1   bus read strobe
//  wr       in   1   bus write strobe
//  addr     in   32  byte address
//  wdata    in   32  write data
//  rdata    out  32  read data; combinational from addr; 0 when outside window or rd=0
//  uart_rx  in   1   serial input, asynchronous, idle high
//  uart_tx  out  1   serial output, idle high
//  irqout   out  1   level interrupt request
// BEHAVIOUR
//  Reset: uart_tx=1, irqout=0, FIFOs empty, CTRL=0, DIV=BAUD_DIV_RST, overrun=0, frame_err=0, both FSMs IDLE.
//  Register map (offset = addr[3:2]):
//   0 DATA   rd: {24'b0, RX head}; pops RX when non-empty; returns 0 with no pop when empty.
//            wr: pushes wdata[7:0] to TX; write while TX full is dropped silently.
//   1 STATUS rd: {26'b0, frame_err, overrun, tx_full, tx_empty, rx_full, rx_empty}.
//            wr: 1 in bit 5 clears frame_err, 1 in bit 4 clears overrun.
//   2 CTRL   rw: bit0 enable, bit1 rx_ie, bit2 tx_ie; other bits read 0.
//   3 BAUD   rw: [15:0] DIV.
//  Every rd/wr cycle counts as one access: rd high for N cycles on DATA pops N bytes.
//  Tick generator: 16-bit counter. While enable=1, tick pulses when count==DIV; the counter then reloads to 0.
//   It is held at 0 while enable=0. A write to BAUD also zeroes it.
//  Frame: 8N1, LSB first; one bit = 16 ticks.
//  RX: uart_rx passes through a 2-flop synchroniser.
//   IDLE -> START on a sampled low while enable=1.
//   START: at tick 7, line still low -> DATA; else -> IDLE (glitch rejected).
//   DATA: sample each bit at its mid-point (every 16 ticks), 8 bits -> STOP.
//   STOP: at mid-point, line high -> push byte; line low -> set frame_err, discard byte. Then -> IDLE.
//   Push while RX full -> byte dropped and overrun set. Exception: a CPU pop in the same cycle frees a slot and the push succeeds.
//  TX: IDLE -> START when enable=1 and TX non-empty; the pop happens on that transition.
//   Drive start(0), 8 data bits, stop(1), each 16 ticks, then -> IDLE.
//   Back-to-back bytes have no idle gap.
//  FIFO: simultaneous push+pop while full or empty is legal. Full: both happen and count is unchanged. Empty: push only.
//   Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
//  Clearing enable mid-frame: both FSMs abort to IDLE at once, uart_tx=1, FIFO contents kept.
//  irqout = (rx_ie & (~rx_empty | overrun | frame_err)) | (tx_ie & tx_empty). Registered: one cycle after cause.
//  Async reset mid-frame: immediate return to reset state, partial byte lost.
// STRUCTURE
//  Shared package uart_pkg: register offsets REG_DATA/REG_STATUS/REG_CTRL/REG_BAUD, STATUS/CTRL bit indices, FSM state encodings.
//  Sub-module uart_sync_fifo (WIDTH=8, DEPTH) instantiated twice; ports push/pop/din/dout/full/empty.
//  Tick generator, RX FSM, TX FSM and register decode stay inline.
// TESTING (DIV=0 for simulation: 1 bit = 16 clk)
//  Reset with reset=0 mid-frame -> uart_tx=1, irqout=0, STATUS=32'h0000_0005, BAUD reads 324.
//  enable=1, write DATA 8'hA5 -> uart_tx shows 0,1,0,1,0,0,1,0,1,1, 16 clk each; then tx_empty=1.
//  Drive serial 8'h3C into uart_rx -> rx_empty=0, irqout=1 with rx_ie; DATA read = 32'h3C, then rx_empty=1.
//  Send FIFO_DEPTH+1 bytes unread -> rx_full=1, overrun=1; first FIFO_DEPTH bytes read intact; STATUS write 32'h10 clears overrun.
//  Stop bit forced low -> frame_err=1, no push; 2-clk low glitch on idle line -> no byte, FSM back to IDLE.
//  Fill TX to full, write once more -> extra byte dropped; pop+push on full RX in the same cycle -> count stays FIFO_DEPTH, order preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, bit indices and FSM encodings for the UART
package uart_pkg;

   // Register offsets, selected by addr[3:2]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_BAUD   = 2'd3;

   // STATUS bit positions
   localparam int ST_RX_EMPTY  = 0;
   localparam int ST_RX_FULL   = 1;
   localparam int ST_TX_EMPTY  = 2;
   localparam int ST_TX_FULL   = 3;
   localparam int ST_OVERRUN   = 4;
   localparam int ST_FRAME_ERR = 5;

   // CTRL bit positions
   localparam int CT_ENABLE = 0;
   localparam int CT_RX_IE  = 1;
   localparam int CT_TX_IE  = 2;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through synchronous FIFO for UART bytes
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if a pop frees the slot
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array write port
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/uart_fifo_periph.sv
// rtl/uart_fifo_periph.sv - memory-mapped 8N1 UART with TX/RX FIFOs, baud divisor and interrupt
module uart_fifo_periph
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h4000_0020,
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [15:0] BAUD_DIV_RST = 16'd324
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irqout
);
   logic [1:0]  off;
   logic        sel, baud_wr, status_wr;
   logic [2:0]  ctrl;
   logic        enable, rx_ie, tx_ie;
   logic [15:0] div, tick_cnt;
   logic        tick;
   logic        overrun, frame_err;
   logic        rx_full, rx_empty, tx_full, tx_empty;
   logic [7:0]  rx_dout, tx_dout;
   logic        rx_pop, rx_push, rx_ferr, tx_push, tx_pop;
   logic        rx_s1, rx_in;
   rx_state_t   rx_state;
   logic [3:0]  rx_ticks;
   logic [2:0]  rx_bits;
   logic [7:0]  rx_shift;
   tx_state_t   tx_state;
   logic [3:0]  tx_ticks;
   logic [2:0]  tx_bits;
   logic [7:0]  tx_shift;
   logic        tx_bit_end;
   logic        unused_bits;

   assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
   assign off         = addr[3:2];
   assign baud_wr     = wr && sel && (off == REG_BAUD);
   assign status_wr   = wr && sel && (off == REG_STATUS);
   assign rx_pop      = rd && sel && (off == REG_DATA);
   assign tx_push     = wr && sel && (off == REG_DATA);
   assign enable      = ctrl[CT_ENABLE];
   assign rx_ie       = ctrl[CT_RX_IE];
   assign tx_ie       = ctrl[CT_TX_IE];
   assign unused_bits = ^{addr[1:0], wdata[31:16]};

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_shift),
      .dout(rx_dout), .full(rx_full), .empty(rx_empty)
   );

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
      .dout(tx_dout), .full(tx_full), .empty(tx_empty)
   );

   // Read mux: combinational from addr, zero outside the window or without rd
   always_comb begin
      rdata = '0;
      if (rd && sel) begin
         case (off)
            REG_DATA:   rdata = {24'b0, rx_empty ? 8'h00 : rx_dout};
            REG_STATUS: rdata = {26'b0, frame_err, overrun, tx_full, tx_empty, rx_full, rx_empty};
            REG_CTRL:   rdata = {29'b0, ctrl};
            default:    rdata = {16'b0, div};
         endcase
      end
   end

   // CTRL and BAUD registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl <= '0;
         div  <= BAUD_DIV_RST;
      end else if (wr && sel) begin
         if (off == REG_CTRL) ctrl <= wdata[2:0];
         if (off == REG_BAUD) div  <= wdata[15:0];
      end
   end

   // Sticky error flags; a new error in the same cycle as a clear wins so no event is lost
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (status_wr && wdata[ST_FRAME_ERR]) frame_err <= 1'b0;
         if (status_wr && wdata[ST_OVERRUN])   overrun   <= 1'b0;
         if (rx_push && rx_full && !rx_pop)    overrun   <= 1'b1;
         if (rx_ferr)                          frame_err <= 1'b1;
      end
   end

   // 16x oversampling tick: one pulse every DIV+1 clocks while enabled
   assign tick = enable && (tick_cnt == div);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                         tick_cnt <= '0;
      else if (!enable || baud_wr || tick) tick_cnt <= '0;
      else                                tick_cnt <= tick_cnt + 16'd1;
   end

   // Two-flop synchroniser for the asynchronous serial input
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_s1 <= 1'b1;
         rx_in <= 1'b1;
      end else begin
         rx_s1 <= uart_rx;
         rx_in <= rx_s1;
      end
   end

   // RX FSM: mid-bit sampling, emits one-cycle push or framing-error pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state <= RX_IDLE;
         rx_ticks <= '0;
         rx_bits  <= '0;
         rx_shift <= '0;
         rx_push  <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_push <= 1'b0;
         rx_ferr <= 1'b0;
         if (!enable) begin
            rx_state <= RX_IDLE;
         end else begin
            case (rx_state)
               RX_IDLE: if (!rx_in) begin
                  rx_state <= RX_START;
                  rx_ticks <= '0;
               end
               RX_START: if (tick) begin
                  if (rx_ticks == 4'd7) begin
                     rx_ticks <= '0;
                     rx_bits  <= '0;
                     rx_state <= rx_in ? RX_IDLE : RX_DATA;
                  end else begin
                     rx_ticks <= rx_ticks + 4'd1;
                  end
               end
               RX_DATA: if (tick) begin
                  rx_ticks <= rx_ticks + 4'd1;
                  if (rx_ticks == 4'd15) begin
                     rx_shift <= {rx_in, rx_shift[7:1]};
                     rx_bits  <= rx_bits + 3'd1;
                     if (rx_bits == 3'd7) rx_state <= RX_STOP;
                  end
               end
               default: if (tick) begin
                  rx_ticks <= rx_ticks + 4'd1;
                  if (rx_ticks == 4'd15) begin
                     if (rx_in) rx_push <= 1'b1;
                     else       rx_ferr <= 1'b1;
                     rx_state <= RX_IDLE;
                  end
               end
            endcase
         end
      end
   end

   // A byte is pulled from the TX FIFO when leaving IDLE or at the end of a stop bit, so frames chain without a gap
   assign tx_bit_end = tick && (tx_ticks == 4'd15);
   assign tx_pop     = enable && !tx_empty &&
                       ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));

   // TX FSM: start, eight data bits LSB first, stop, with uart_tx registered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         tx_ticks <= '0;
         tx_bits  <= '0;
         tx_shift <= '0;
         uart_tx  <= 1'b1;
      end else if (!enable) begin
         tx_state <= TX_IDLE;
         uart_tx  <= 1'b1;
      end else begin
         if ((tx_state != TX_IDLE) && tick) tx_ticks <= tx_ticks + 4'd1;
         case (tx_state)
            TX_IDLE: if (tx_pop) begin
               tx_state <= TX_START;
               tx_shift <= tx_dout;
               tx_ticks <= '0;
               uart_tx  <= 1'b0;
            end
            TX_START: if (tx_bit_end) begin
               tx_state <= TX_DATA;
               tx_bits  <= '0;
               uart_tx  <= tx_shift[0];
            end
            TX_DATA: if (tx_bit_end) begin
               if (tx_bits == 3'd7) begin
                  tx_state <= TX_STOP;
                  uart_tx  <= 1'b1;
               end else begin
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  uart_tx  <= tx_shift[1];
                  tx_bits  <= tx_bits + 3'd1;
               end
            end
            default: if (tx_bit_end) begin
               if (tx_pop) begin
                  tx_state <= TX_START;
                  tx_shift <= tx_dout;
                  uart_tx  <= 1'b0;
               end else begin
                  tx_state <= TX_IDLE;
               end
            end
         endcase
      end
   end

   // Level interrupt, registered one cycle behind its causes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) irqout <= 1'b0;
      else        irqout <= (rx_ie && (!rx_empty || overrun || frame_err)) || (tx_ie && tx_empty);
   end

endmodule

// File: tb/tb_uart_fifo_periph.sv
// tb/tb_uart_fifo_periph.sv - randomized self-checking bench for uart_fifo_periph
module tb_uart_fifo_periph;
   localparam int DEPTH = 16;
   localparam logic [31:0] A_DATA   = 32'h4000_0020;
   localparam logic [31:0] A_STATUS = 32'h4000_0024;
   localparam logic [31:0] A_CTRL   = 32'h4000_0028;
   localparam logic [31:0] A_BAUD   = 32'h4000_002C;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        uart_rx = 1'b1;
   logic        uart_tx;
   logic        irqout;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] rx_model [$];
   logic [9:0] tx_frames [$];

   always #5 clk = ~clk;

   uart_fifo_periph #(.BASE_ADDR(32'h4000_0020), .FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(16'd324)) dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irqout(irqout)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk); wr = 1'b1; addr = a; wdata = d;
      @(negedge clk); wr = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk); rd = 1'b1; addr = a;
      #1 d = rdata;
      @(negedge clk); rd = 1'b0;
   endtask

   // Drives one 8N1 frame (16 clk per bit) plus idle time; mode 1 polls STATUS every cycle
   // and reports the first cycle rx_full is seen, mode 2 reads DATA exactly on cycle pop_at.
   task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int mode,
                              input int pop_at, output int full_at, output logic [7:0] popped);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      full_at = -1;
      popped = '0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         uart_rx = (c < 160) ? bits[c/16] : 1'b1;
         if (mode == 1) begin
            rd = 1'b1; addr = A_STATUS;
            #1 if (rdata[1] && full_at < 0) full_at = c;
         end else if (mode == 2) begin
            rd = (c == pop_at); addr = A_DATA;
            #1 if (c == pop_at) popped = rdata[7:0];
         end
      end
      rd = 1'b0;
   endtask

   // Waits for a start bit, then samples nframes frames at bit mid-points into tx_frames
   task automatic capture_tx(input int nframes, output logic started);
      int waited;
      logic [9:0] fr;
      waited = 0;
      started = 1'b0;
      tx_frames.delete();
      while (uart_tx !== 1'b0 && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (uart_tx === 1'b0) begin
         started = 1'b1;
         repeat (7) @(negedge clk);
         for (int f = 0; f < nframes; f++) begin
            for (int k = 0; k < 10; k++) begin
               fr[k] = uart_tx;
               repeat (16) @(negedge clk);
            end
            tx_frames.push_back(fr);
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      bus_write(A_BAUD, 32'h0);
      bus_write(A_CTRL, 32'h7);
      bus_write(A_DATA, $urandom);
      repeat (37) @(negedge clk);
      vectors++;
      if (irqout !== 1'b1) begin miscompares++; $display("FAIL pre_reset_irq: got %b expected 1", irqout); end
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
      vectors++;
      if (irqout !== 1'b0) begin miscompares++; $display("FAIL reset_irqout: got %b expected 0", irqout); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      vectors++;
      if (rdata !== 32'h0) begin miscompares++; $display("FAIL rdata_idle: got %h expected 0", rdata); end
      bus_read(A_STATUS, d);
      vectors++;
      if (d !== 32'h5) begin miscompares++; $display("FAIL reset_status: got %h expected 00000005", d); end
      bus_read(A_BAUD, d);
      vectors++;
      if (d !== 32'd324) begin miscompares++; $display("FAIL reset_baud: got %0d expected 324", d); end
      bus_read(A_CTRL, d);
      vectors++;
      if (d !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h expected 0", d); end
      bus_read(A_DATA, d);
      vectors++;
      if (d !== 32'h0) begin miscompares++; $display("FAIL reset_data_empty: got %h expected 0", d); end
      bus_read(A_BAUD + 32'h4, d);
      vectors++;
      if (d !== 32'h0) begin miscompares++; $display("FAIL out_of_window: got %h expected 0", d); end
   endtask

   task automatic test_regs();
      logic [31:0] d, v;
      v = $urandom;
      bus_write(A_BAUD, v);
      bus_read(A_BAUD, d);
      vectors++;
      if (d !== {16'h0, v[15:0]}) begin miscompares++; $display("FAIL baud_rw: got %h expected %h", d, {16'h0, v[15:0]}); end
      v = $urandom;
      bus_write(A_CTRL, v);
      bus_read(A_CTRL, d);
      vectors++;
      if (d !== (v & 32'h7)) begin miscompares++; $display("FAIL ctrl_rw: got %h expected %h", d, v & 32'h7); end
      bus_write(A_CTRL, 32'h0);
      bus_write(A_BAUD, 32'h0);
   endtask

   task automatic test_tx();
      logic [7:0] b;
      logic [31:0] d;
      logic ok;
      bus_write(A_CTRL, 32'h1);
      for (int i = 0; i < 5; i++) begin
         b = (i == 0) ? 8'hA5 : 8'($urandom);
         bus_write(A_DATA, {24'h0, b});
         capture_tx(1, ok);
         vectors++;
         if (!ok) begin
            miscompares++; $display("FAIL tx_start_timeout: byte %h never started", b);
         end else if (tx_frames[0] !== {1'b1, b, 1'b0}) begin
            miscompares++; $display("FAIL tx_frame: got %b expected %b", tx_frames[0], {1'b1, b, 1'b0});
         end
         bus_read(A_STATUS, d);
         vectors++;
         if (d !== 32'h5) begin miscompares++; $display("FAIL tx_done_status: got %h expected 00000005", d); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bs [3];
      logic ok;
      bus_write(A_CTRL, 32'h0);
      for (int i = 0; i < 3; i++) begin
         bs[i] = 8'($urandom);
         bus_write(A_DATA, {24'h0, bs[i]});
      end
      bus_write(A_CTRL, 32'h1);
      capture_tx(3, ok);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (!ok) begin
            miscompares++; $display("FAIL b2b_timeout: frame %0d never started", i);
         end else if (tx_frames[i] !== {1'b1, bs[i], 1'b0}) begin
            miscompares++; $display("FAIL b2b_frame%0d: got %b expected %b", i, tx_frames[i], {1'b1, bs[i], 1'b0});
         end
      end
   endtask

   task automatic test_tx_full();
      logic [7:0] bs [DEPTH+1];
      logic [31:0] d;
      logic ok;
      int lows;
      bus_write(A_CTRL, 32'h0);
      for (int i = 0; i <= DEPTH; i++) begin
         bs[i] = 8'($urandom);
         bus_write(A_DATA, {24'h0, bs[i]});
      end
      bus_read(A_STATUS, d);
      vectors++;
      if (d !== 32'h9) begin miscompares++; $display("FAIL tx_full_status: got %h expected 00000009", d); end
      bus_write(A_CTRL, 32'h1);
      capture_tx(DEPTH, ok);
      for (int i = 0; i < DEPTH; i++) begin
         vectors++;
         if (!ok) begin
            miscompares++; $display("FAIL tx_full_timeout: frame %0d never started", i);
         end else if (tx_frames[i] !== {1'b1, bs[i], 1'b0}) begin
            miscompares++; $display("FAIL tx_full_frame%0d: got %b expected %b", i, tx_frames[i], {1'b1, bs[i], 1'b0});
         end
      end
      lows = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      vectors++;
      if (lows != 0) begin miscompares++; $display("FAIL tx_dropped_byte_sent: got %0d low cycles expected 0", lows); end
   endtask

   task automatic test_rx();
      logic [7:0] b, p;
      logic [31:0] d;
      int fa;
      bus_write(A_CTRL, 32'h3);
      for (int i = 0; i < 5; i++) begin
         b = (i == 0) ? 8'h3C : 8'($urandom);
         drive_frame(b, 1'b1, 0, 0, fa, p);
         bus_read(A_STATUS, d);
         vectors++;
         if (d !== 32'h4) begin miscompares++; $display("FAIL rx_status_full: got %h expected 00000004", d); end
         vectors++;
         if (irqout !== 1'b1) begin miscompares++; $display("FAIL rx_irq: got %b expected 1", irqout); end
         bus_read(A_DATA, d);
         vectors++;
         if (d !== {24'h0, b}) begin miscompares++; $display("FAIL rx_data: got %h expected %h", d, {24'h0, b}); end
         bus_read(A_STATUS, d);
         vectors++;
         if (d !== 32'h5) begin miscompares++; $display("FAIL rx_status_empty: got %h expected 00000005", d); end
         vectors++;
         if (irqout !== 1'b0) begin miscompares++; $display("FAIL rx_irq_clear: got %b expected 0", irqout); end
      end
   endtask

   task automatic test_tx_irq();
      bus_write(A_CTRL, 32'h5);
      @(negedge clk);
      vectors++;
      if (irqout !== 1'b1) begin miscompares++; $display("FAIL tx_irq: got %b expected 1", irqout); end
      bus_write(A_CTRL, 32'h1);
      @(negedge clk);
      vectors++;
      if (irqout !== 1'b0) begin miscompares++; $display("FAIL tx_irq_off: got %b expected 0", irqout); end
   endtask

   task automatic test_overrun();
      logic [7:0] b, p;
      logic [31:0] d;
      int fa;
      bus_write(A_CTRL, 32'h1);
      rx_model.delete();
      for (int i = 0; i <= DEPTH; i++) begin
         b = 8'($urandom);
         if (rx_model.size() < DEPTH) rx_model.push_back(b);
         drive_frame(b, 1'b1, 0, 0, fa, p);
      end
      bus_read(A_STATUS, d);
      vectors++;
      if (d !== 32'h16) begin miscompares++; $display("FAIL overrun_status: got %h expected 00000016", d); end
      for (int i = 0; i < DEPTH; i++) begin
         b = rx_model.pop_front();
         bus_read(A_DATA, d);
         vectors++;
         if (d !== {24'h0, b}) begin miscompares++; $display("FAIL overrun_data%0d: got %h expected %h", i, d, {24'h0, b}); end
      end
      bus_read(A_STATUS, d);
      vectors++;
      if (d !== 32'h15) begin miscompares++; $display("FAIL overrun_drained: got %h expected 00000015", d); end
      bus_write(A_STATUS, 32'h10);
      bus_read(A_STATUS, d);
      vectors++;
      if (d !== 32'h5) begin miscompares++; $display("FAIL overrun_clear: got %h expected 00000005", d); end
   endtask

   task automatic test_frame_err();
      logic [7:0] b, p;
      logic [31:0] d;
      int fa;
      bus_write(A_CTRL, 32'h1);
      drive_frame(8'($urandom), 1'b0, 0, 0, fa, p);
      bus_read(A_STATUS, d);
      vectors++;
      if (d !== 32'h25) begin miscompares++; $display("FAIL frame_err_status: got %h expected 00000025", d); end
      bus_write(A_STATUS, 32'h20);
      bus_read(A_STATUS, d);
      vectors++;
      if (d !== 32'h5) begin miscompares++; $display("FAIL frame_err_clear: got %h expected 00000005", d); end
      @(negedge clk); uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      bus_read(A_STATUS, d);
      vectors++;
      if (d !== 32'h5) begin miscompares++; $display("FAIL glitch_status: got %h expected 00000005", d); end
      b = 8'($urandom);
      drive_frame(b, 1'b1, 0, 0, fa, p);
      bus_read(A_DATA, d);
      vectors++;
      if (d !== {24'h0, b}) begin miscompares++; $display("FAIL after_glitch_data: got %h expected %h", d, {24'h0, b}); end
   endtask

   task automatic test_pop_push_full();
      logic [7:0] b, p, exp_pop;
      logic [31:0] d;
      int fa, dummy;
      bus_write(A_CTRL, 32'h1);
      bus_write(A_STATUS, 32'h30);
      rx_model.delete();
      for (int i = 0; i < DEPTH - 1; i++) begin
         b = 8'($urandom);
         rx_model.push_back(b);
         drive_frame(b, 1'b1, 0, 0, fa, p);
      end
      b = 8'($urandom);
      rx_model.push_back(b);
      drive_frame(b, 1'b1, 1, 0, fa, p);
      vectors++;
      if (fa < 1) begin
         miscompares++; $display("FAIL fill_timeout: rx_full never seen, got %0d", fa);
      end else begin
         b = 8'($urandom);
         exp_pop = rx_model.pop_front();
         rx_model.push_back(b);
         drive_frame(b, 1'b1, 2, fa - 1, dummy, p);
         if (p !== exp_pop) begin miscompares++; $display("FAIL same_cycle_pop: got %h expected %h", p, exp_pop); end
      end
      bus_read(A_STATUS, d);
      vectors++;
      if (d !== 32'h6) begin miscompares++; $display("FAIL same_cycle_status: got %h expected 00000006", d); end
      for (int i = 0; i < DEPTH; i++) begin
         b = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
         bus_read(A_DATA, d);
         vectors++;
         if (d !== {24'h0, b}) begin miscompares++; $display("FAIL same_cycle_order%0d: got %h expected %h", i, d, {24'h0, b}); end
      end
      bus_read(A_STATUS, d);
      vectors++;
      if (d !== 32'h5) begin miscompares++; $display("FAIL same_cycle_drained: got %h expected 00000005", d); end
   endtask

   initial begin
      test_reset();
      test_regs();
      test_tx();
      test_back_to_back();
      test_tx_full();
      test_rx();
      test_tx_irq();
      test_overrun();
      test_frame_err();
      test_pop_push_full();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
